// File: rtl/reg_op_arbiter_if.sv
// Request/operation bundle between requesters, the arbiter and the shared register.
// REG_ARB_LOCK_EN adds the per-requester req_lock input.
interface reg_op_arbiter_if #(
  parameter int N_REQ = 4
);
  localparam int GW = $clog2(N_REQ);

  logic [N_REQ-1:0]    req;
  logic [2*N_REQ-1:0]  req_funsel;
  logic [16*N_REQ-1:0] req_data;
`ifdef REG_ARB_LOCK_EN
  logic [N_REQ-1:0]    req_lock;
`endif
  logic [N_REQ-1:0]    ack;
  logic                E;
  logic [1:0]          FunSel;
  logic [15:0]         In;
  logic [GW-1:0]       grant_id;
  logic                busy;

`ifdef REG_ARB_LOCK_EN
  modport master (
    output req, req_funsel, req_data, req_lock,
    input  ack, E, FunSel, In, grant_id, busy
  );
  modport slave (
    input  req, req_funsel, req_data, req_lock,
    output ack, E, FunSel, In, grant_id, busy
  );
`else
  modport master (
    output req, req_funsel, req_data,
    input  ack, E, FunSel, In, grant_id, busy
  );
  modport slave (
    input  req, req_funsel, req_data,
    output ack, E, FunSel, In, grant_id, busy
  );
`endif
endinterface

// File: rtl/reg_op_arbiter.sv
// Round-robin arbiter sequencing dec/inc/load/clear ops onto one shared register.
// Optional REG_ARB_LOCK_EN lets a granted requester retain top priority.
module reg_op_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic             clock,
  input  logic             reset,
  reg_op_arbiter_if.slave  bus
);
  localparam int GW = $clog2(N_REQ);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_ACK   = 2'd2
  } state_t;

  state_t           r_state;
  logic [GW-1:0]    r_ptr;
  logic [GW-1:0]    r_gid;
  logic [N_REQ-1:0] r_ack;
  logic             r_e;
  logic [1:0]       r_funsel;
  logic [15:0]      r_in;
  logic             r_busy;

  logic             w_found;
  logic [GW-1:0]    w_win;
  logic [GW-1:0]    w_cand;
  logic [GW-1:0]    w_ptr_nxt;
  logic [1:0]       w_fs;
  logic [15:0]      w_data;

  // Scan downward so the candidate closest to r_ptr is assigned last.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_cand = GW'((int'(r_ptr) + k) % N_REQ);
      if (bus.req[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  assign w_fs   = bus.req_funsel[{w_win, 1'b0} +: 2];
  assign w_data = bus.req_data[{w_win, 4'b0000} +: 16];

  always_comb begin
    w_ptr_nxt = (r_gid == GW'(N_REQ - 1)) ? '0 : r_gid + GW'(1);
`ifdef REG_ARB_LOCK_EN
    if (bus.req_lock[r_gid]) begin
      w_ptr_nxt = r_gid;
    end
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_ptr    <= '0;
      r_gid    <= '0;
      r_ack    <= '0;
      r_e      <= 1'b0;
      r_funsel <= 2'b00;
      r_in     <= 16'h0000;
      r_busy   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_gid    <= w_win;
            r_funsel <= w_fs;
            r_in     <= w_data;
            r_e      <= 1'b1;
            r_busy   <= 1'b1;
            r_state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_e     <= 1'b0;
          r_ack   <= N_REQ'(1) << r_gid;
          r_state <= S_ACK;
        end
        S_ACK: begin
          r_ack   <= '0;
          r_busy  <= 1'b0;
          r_ptr   <= w_ptr_nxt;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ack      = r_ack;
  assign bus.E        = r_e;
  assign bus.FunSel   = r_funsel;
  assign bus.In       = r_in;
  assign bus.grant_id = r_gid;
  assign bus.busy     = r_busy;
endmodule

// File: doc/reg_op_arbiter.md
# reg_op_arbiter

Round-robin arbiter and sequencer that shares one `register_16bit` instance among `N_REQ` requesters. It accepts one operation request per requester: decrement, increment, load, or clear. It picks one winner at a time and drives the register's `E`/`FunSel`/`In` for exactly one cycle. It then returns a one-cycle acknowledge to the winner. It sits between datapath control units and a shared 16-bit register.

## Interface
- `N_REQ`, 4, number of requesters; legal range 2..8.
- `GW`, derived = `$clog2(N_REQ)`, width of the grant id.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `req`  in  N_REQ  per-requester request; held high until that requester's `ack`.
- `req_funsel`  in  2*N_REQ  requester i op at [2i+1:2i]; encoding: 00 dec, 01 inc, 10 load, 11 clear.
- `req_data`  in  16*N_REQ  requester i load data at [16i+15:16i]; ignored unless op = 10.
- `ack`  out  N_REQ  one-hot, one-cycle pulse; the granted op has been applied to the register.
- `E`  out  1  register enable; connects to register `E`.
- `FunSel`  out  2  connects to register `FunSel`.
- `In`  out  16  connects to register `In`.
- `grant_id`  out  GW  index of the current or last winner.
- `busy`  out  1  high in ISSUE and ACK.

## Operation
- All outputs are registered.
- Reset values: `ack`=0, `E`=0, `FunSel`=00, `In`=0, `grant_id`=0, `busy`=0, state=IDLE, priority pointer `ptr`=0.
- State machine: IDLE -> ISSUE -> ACK -> IDLE.
- IDLE: if `req`≠0, choose the winner as the first set bit searching upward from `ptr`, wrapping N_REQ-1 -> 0.
  - Latch the winner's id into `grant_id`.
  - Latch its funsel and data.
  - Go to ISSUE.
  - If `req`=0, stay in IDLE with `E`=0.
- ISSUE: `E`=1, `FunSel`/`In` = latched values, for exactly one cycle. Go to ACK.
- ACK:
  - `E`=0.
  - `ack[grant_id]`=1.
  - `ptr` = (`grant_id`+1) mod N_REQ; the modulo also applies for non-power-of-2 N_REQ.
  - Go to IDLE.
- `FunSel`/`In` hold their last value while `E`=0. `In` is driven with the latched data for every op, not only loads.
- Requests are sampled only in IDLE. Changes to `req`/`req_funsel`/`req_data` during ISSUE or ACK are ignored for the current op.
- If a requester drops `req` after being latched, its op still completes and `ack` is still pulsed.
- A requester that keeps `req` high after its `ack` is treated as a new request. It competes at its new, lowest priority.
- Register arithmetic (wrap at 0x0000/0xFFFF) is the register's responsibility. The arbiter performs no arithmetic on data.
- Reset asserted mid-operation: all outputs clear immediately and asynchronously.
  - An op in ISSUE may or may not have been captured by the register, depending on edge alignment.
  - No `ack` is issued for it.
  - `ptr` returns to 0.

## Timing
- Request sampled at edge t0 (IDLE).
- ISSUE during cycle t0..t1, with `E`=1. The register updates at edge t1.
- ACK during t1..t2. The register `Out` already shows the new value in this cycle.
- IDLE again from t2; the next sample is at edge t2.
- Latency from sampling edge to `ack` high: 1 cycle.
- Throughput: at most one op per 3 cycles.
- With continuous requests from all requesters, each waits at most 3*(N_REQ-1) cycles between ack and next sample win.

## Configuration
- Macro: `REG_ARB_LOCK_EN`.
- Defined: adds input port `req_lock` (N_REQ). If `req_lock[grant_id]`=1 during ACK, `ptr` = `grant_id`, so the same requester keeps top priority for back-to-back ops, e.g. a read-modify sequence.
- Not defined: the port is absent and `ptr` always advances to `grant_id`+1.

## Test plan
- Reset, then single request: `req`=0001, funsel 10, data 0x1234 -> `E`=1 with `In`=0x1234 one cycle after sampling, `ack`=0001 next cycle, register reads 0x1234.
- All four request together, starting at `ptr`=0: ops inc, inc, dec, clear -> grant order 0,1,2,3, acks 3 cycles apart. Register from 0x0005 ends at 0x0000; the intermediate values 6,7,6 are checked at each ack.
- Requester 2 holds `req` continuously while requester 0 requests once after 2's first ack -> order 2,0,2, `ptr` rotation verified.
- Requester 1 drops `req` during ISSUE -> `ack[1]` is still pulsed and its op is applied.
- Reset asserted during ACK -> `ack`, `E`, `busy` go low immediately. `grant_id`=0 and the next arbitration starts from `ptr`=0.
- With `REG_ARB_LOCK_EN`: `req`=0011, `req_lock[1]`=1 with `ptr` at 1 -> requester 1 wins three consecutive ops. After `req_lock` drops, requester 0 wins next.
